// File: rtl/op_ctrl_gen.sv
`timescale 1ns/1ps
// op_ctrl_gen
// Sequential initiator for a unified-buffer op port. After a start pulse it
// waits START_DELAY cycles, then walks a 3-deep nested loop nest
// (EXT0 x EXT1 x EXT2). It raises en at most once every II cycles and
// presents the loop indices on ctrl_vars. stall freezes all sequencing.
// flush aborts the sweep and returns the block to idle.
// Optional feature: define OP_CTRL_HALF_VARS_EN to add the half_vars output
// (each ctrl_vars entry shifted right by one).
module op_ctrl_gen #(
  parameter int CTRL_W      = 16,
  parameter int EXT0        = 1,
  parameter int EXT1        = 64,
  parameter int EXT2        = 64,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              stall,
  output logic              en,
  output logic [CTRL_W-1:0] ctrl_vars [3],
`ifdef OP_CTRL_HALF_VARS_EN
  output logic [CTRL_W-1:0] half_vars [3],
`endif
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN} state_t;

  // A zero start delay skips the DELAY state entirely.
  localparam state_t START_ST = (START_DELAY > 0) ? S_DELAY : S_RUN;

  // Terminal values. An extent of 2^CTRL_W maps to all-ones, so the index
  // wraps naturally at the top of its range.
  localparam logic [CTRL_W-1:0] LAST0    = CTRL_W'(EXT0 - 1);
  localparam logic [CTRL_W-1:0] LAST1    = CTRL_W'(EXT1 - 1);
  localparam logic [CTRL_W-1:0] LAST2    = CTRL_W'(EXT2 - 1);
  localparam logic [CTRL_W-1:0] DLY_LAST = CTRL_W'(START_DELAY - 1);
  localparam logic [CTRL_W-1:0] II_LAST  = CTRL_W'(II - 1);
  localparam logic [CTRL_W-1:0] ONE      = CTRL_W'(1);

  state_t            state_q;
  logic [CTRL_W-1:0] delay_cnt_q;
  logic [CTRL_W-1:0] ii_cnt_q;
  logic [CTRL_W-1:0] idx_q [3];
  logic [CTRL_W-1:0] idx_d [3];
  logic              done_q;
  logic              wrap2;
  logic              wrap1;
  logic              last_pt;

  // Odometer advance of the loop indices: the innermost index moves fastest.
  always_comb begin
    wrap2    = (idx_q[2] == LAST2);
    wrap1    = (idx_q[1] == LAST1);
    last_pt  = wrap2 && wrap1 && (idx_q[0] == LAST0);
    idx_d[0] = idx_q[0];
    idx_d[1] = idx_q[1];
    idx_d[2] = idx_q[2] + ONE;
    if (wrap2) begin
      idx_d[2] = '0;
      idx_d[1] = wrap1 ? '0 : (idx_q[1] + ONE);
      if (wrap1) begin
        idx_d[0] = idx_q[0] + ONE;
      end
    end
  end

  // Sequencing FSM: flush wins over everything, and stall freezes state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      delay_cnt_q <= '0;
      ii_cnt_q    <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) idx_q[i] <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      delay_cnt_q <= '0;
      ii_cnt_q    <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) idx_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (!stall) begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q     <= START_ST;
              delay_cnt_q <= '0;
              ii_cnt_q    <= '0;
            end
          end
          S_DELAY: begin
            if (delay_cnt_q == DLY_LAST) begin
              state_q     <= S_RUN;
              delay_cnt_q <= '0;
              ii_cnt_q    <= '0;
            end else begin
              delay_cnt_q <= delay_cnt_q + ONE;
            end
          end
          S_RUN: begin
            ii_cnt_q <= (ii_cnt_q == II_LAST) ? '0 : (ii_cnt_q + ONE);
            if (ii_cnt_q == '0) begin
              if (last_pt) begin
                state_q  <= S_IDLE;
                ii_cnt_q <= '0;
                done_q   <= 1'b1;
                for (int i = 0; i < 3; i++) idx_q[i] <= '0;
              end else begin
                for (int i = 0; i < 3; i++) idx_q[i] <= idx_d[i];
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign en   = (state_q == S_RUN) && (ii_cnt_q == '0) && !stall;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_vars
    assign ctrl_vars[gi] = idx_q[gi];
`ifdef OP_CTRL_HALF_VARS_EN
    assign half_vars[gi] = idx_q[gi] >> 1;
`endif
  end

endmodule

// File: tb/tb_op_ctrl_gen.sv
`timescale 1ns/1ps
// tb_op_ctrl_gen: several op_ctrl_gen configurations, each checked every
// cycle against a linear-point-index model, plus directed literal scenarios.
module tb_op_ctrl_gen;

  localparam int NI = 4;
  localparam int E0S [NI] = '{1, 1, 2, 1};
  localparam int E1S [NI] = '{2, 1, 3, 4};
  localparam int E2S [NI] = '{3, 4, 2, 4};
  localparam int SDS [NI] = '{0, 4, 2, 0};
  localparam int IIS [NI] = '{1, 3, 2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start_s = '0;
  logic [NI-1:0] stall_s = '0;
  logic [NI-1:0] flush_s = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic void chk(string nm, int inst, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, inst, act, exp, $time);
    end
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int E0 = E0S[gi];
    localparam int E1 = E1S[gi];
    localparam int E2 = E2S[gi];
    localparam int SD = SDS[gi];
    localparam int IV = IIS[gi];
    localparam int N  = E0 * E1 * E2;

    logic        en_w, busy_w, done_w;
    logic [15:0] cv_w [3];
`ifdef OP_CTRL_HALF_VARS_EN
    logic [15:0] hv_w [3];
`endif

    op_ctrl_gen #(
      .CTRL_W(16), .EXT0(E0), .EXT1(E1), .EXT2(E2), .START_DELAY(SD), .II(IV)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_s[gi]),
      .start     (start_s[gi]),
      .stall     (stall_s[gi]),
      .en        (en_w),
      .ctrl_vars (cv_w),
`ifdef OP_CTRL_HALF_VARS_EN
      .half_vars (hv_w),
`endif
      .busy      (busy_w),
      .done      (done_w)
    );

    // Model: m_p is the linear index of the next point to emit, m_c counts the
    // non-stalled cycles that remain before the next enable.
    int m_p, m_c, n_p, n_c;
    bit m_busy, m_done, n_busy, n_done;

    always_comb begin
      n_p = m_p; n_c = m_c; n_busy = m_busy; n_done = 1'b0;
      if (flush_s[gi]) begin
        n_p = 0; n_c = 0; n_busy = 1'b0;
      end else if (!m_busy) begin
        if (start_s[gi] && !stall_s[gi]) begin
          n_busy = 1'b1; n_c = SD; n_p = 0;
        end
      end else if (!stall_s[gi]) begin
        if (m_c == 0) begin
          if (m_p == N - 1) begin
            n_p = 0; n_c = 0; n_busy = 1'b0; n_done = 1'b1;
          end else begin
            n_p = m_p + 1; n_c = IV - 1;
          end
        end else begin
          n_c = m_c - 1;
        end
      end
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_p <= 0; m_c <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
        m_p <= n_p; m_c <= n_c; m_busy <= n_busy; m_done <= n_done;
      end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
      chk("en", gi, int'(en_w), (m_busy && m_c == 0 && !stall_s[gi]) ? 1 : 0);
      chk("busy", gi, int'(busy_w), int'(m_busy));
      chk("done", gi, int'(done_w), int'(m_done));
      chk("cv0", gi, int'(cv_w[0]), m_p / (E1 * E2));
      chk("cv1", gi, int'(cv_w[1]), (m_p / E2) % E1);
      chk("cv2", gi, int'(cv_w[2]), m_p % E2);
`ifdef OP_CTRL_HALF_VARS_EN
      chk("hv1", gi, int'(hv_w[1]), ((m_p / E2) % E1) / 2);
      chk("hv2", gi, int'(hv_w[2]), (m_p % E2) / 2);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start0();
    start_s[0] = 1'b1;
    cyc();
    start_s[0] = 1'b0;
  endtask

  int cnt;

  initial begin
    // Reset state
    #3;
    chk("rst_en", 0, int'(g_inst[0].en_w), 0);
    chk("rst_busy", 0, int'(g_inst[0].busy_w), 0);
    chk("rst_done", 0, int'(g_inst[0].done_w), 0);
    chk("rst_cv2", 0, int'(g_inst[0].cv_w[2]), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Basic sweep on inst0, delay/II sweep on inst1, launched together
    start_s = 4'b0011;
    cyc();
    start_s = '0;
    for (int c = 1; c <= 16; c++) begin
      #2;
      chk("basic_en", 0, int'(g_inst[0].en_w), (c >= 1 && c <= 6) ? 1 : 0);
      chk("basic_done", 0, int'(g_inst[0].done_w), (c == 7) ? 1 : 0);
      chk("basic_busy", 0, int'(g_inst[0].busy_w), (c >= 1 && c <= 6) ? 1 : 0);
      if (c <= 6) begin
        chk("basic_cv1", 0, int'(g_inst[0].cv_w[1]), (c - 1) / 3);
        chk("basic_cv2", 0, int'(g_inst[0].cv_w[2]), (c - 1) % 3);
      end
      chk("dly_en", 1, int'(g_inst[1].en_w), (c == 5 || c == 8 || c == 11 || c == 14) ? 1 : 0);
      chk("dly_done", 1, int'(g_inst[1].done_w), (c == 15) ? 1 : 0);
      if (c == 11) chk("dly_cv2", 1, int'(g_inst[1].cv_w[2]), 2);
      cyc();
    end

    // Stall held during the 3rd enable
    start0();
    for (int c = 1; c <= 10; c++) begin
      stall_s[0] = (c == 3 || c == 4);
      #2;
      chk("stall_en", 0, int'(g_inst[0].en_w),
          (c == 1 || c == 2 || (c >= 5 && c <= 8)) ? 1 : 0);
      if (c == 3 || c == 4) begin
        chk("stall_cv0", 0, int'(g_inst[0].cv_w[0]), 0);
        chk("stall_cv1", 0, int'(g_inst[0].cv_w[1]), 0);
        chk("stall_cv2", 0, int'(g_inst[0].cv_w[2]), 2);
      end
      chk("stall_done", 0, int'(g_inst[0].done_w), (c == 9) ? 1 : 0);
      cyc();
    end
    stall_s[0] = 1'b0;

    // Flush during the 4th enable
    start0();
    for (int c = 1; c <= 8; c++) begin
      flush_s[0] = (c == 4);
      #2;
      chk("flush_en", 0, int'(g_inst[0].en_w), (c <= 4) ? 1 : 0);
      chk("flush_done", 0, int'(g_inst[0].done_w), 0);
      if (c >= 5) begin
        chk("flush_busy", 0, int'(g_inst[0].busy_w), 0);
        chk("flush_cv1", 0, int'(g_inst[0].cv_w[1]), 0);
        chk("flush_cv2", 0, int'(g_inst[0].cv_w[2]), 0);
      end
      cyc();
    end
    flush_s[0] = 1'b0;

    // Fresh sweep with a start pulse while busy
    start0();
    cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      start_s[0] = (c == 3);
      #2;
      if (g_inst[0].en_w) cnt++;
      chk("busystart_done", 0, int'(g_inst[0].done_w), (c == 7) ? 1 : 0);
      cyc();
    end
    start_s[0] = 1'b0;
    chk("busystart_count", 0, cnt, 6);

    // Back-to-back sweeps: start in the done cycle
    start0();
    cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      start_s[0] = (c == 7);
      #2;
      if (g_inst[0].en_w) cnt++;
      chk("b2b_en", 0, int'(g_inst[0].en_w), ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)) ? 1 : 0);
      chk("b2b_done", 0, int'(g_inst[0].done_w), (c == 7 || c == 14) ? 1 : 0);
      cyc();
    end
    start_s[0] = 1'b0;
    chk("b2b_count", 0, cnt, 12);

    // Asynchronous reset mid-sweep
    start0();
    cyc();
    cyc();
    #1;
    chk("prerst_busy", 0, int'(g_inst[0].busy_w), 1);
    chk("prerst_cv2", 0, int'(g_inst[0].cv_w[2]), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_en", 0, int'(g_inst[0].en_w), 0);
    chk("arst_busy", 0, int'(g_inst[0].busy_w), 0);
    chk("arst_done", 0, int'(g_inst[0].done_w), 0);
    chk("arst_cv2", 0, int'(g_inst[0].cv_w[2]), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

`ifdef OP_CTRL_HALF_VARS_EN
    // half_vars on the 4x4 sweep
    begin
      int hv_col [4];
      hv_col = '{0, 0, 1, 1};
      start_s[3] = 1'b1;
      cyc();
      start_s[3] = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        #2;
        if (c <= 16) begin
          chk("half_en", 3, int'(g_inst[3].en_w), 1);
          chk("half_hv2", 3, int'(g_inst[3].hv_w[2]), hv_col[(c - 1) % 4]);
          chk("half_hv1", 3, int'(g_inst[3].hv_w[1]), ((c - 1) / 4 >= 2) ? 1 : 0);
        end
        cyc();
      end
    end
`endif

    // Randomized stimulus on all instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        stall_s[i] = ($urandom % 5) == 0;
        flush_s[i] = ($urandom % 60) == 0;
        start_s[i] = !stall_s[i] && (($urandom % 6) == 0);
      end
      cyc();
    end
    start_s = '0;
    stall_s = '0;
    flush_s = '0;
    repeat (40) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_ctrl_gen.md
Name: op_ctrl_gen

Overview:
- Sequential initiator for the unified-buffer op ports: generates the `*_wen`/`*_ren` enable and the 3-entry `ctrl_vars` loop-index vector that buffer ports consume.
- One instance per compute-op port, e.g. `hw_input` write, `nearest_neighbor` read/write, `hw_output` read.
- Walks a 3-deep perfectly nested iteration domain after a programmable start delay, at a programmable initiation interval, with stall and flush support.

Parameters:
- CTRL_W, 16, width of each ctrl_vars entry and of all internal counters.
- EXT0, 1, extent of outermost loop (ctrl_vars[0]); legal range 1..2^CTRL_W.
- EXT1, 64, extent of middle loop (ctrl_vars[1]); legal range 1..2^CTRL_W.
- EXT2, 64, extent of innermost loop (ctrl_vars[2]); legal range 1..2^CTRL_W.
- START_DELAY, 0, cycles between start acceptance and first possible enable; legal range 0..2^CTRL_W-1.
- II, 1, minimum cycles between consecutive enables; legal range 1..2^CTRL_W-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort; returns block to IDLE.
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
- stall  input  1  freezes sequencing while high.
- en  output  1  op enable; drives `*_wen` or `*_ren` of a buffer port.
- ctrl_vars  output  CTRL_W x [2:0]  unpacked array; [0] outermost, [2] innermost; valid whenever en=1.
- busy  output  1  high in DELAY and RUN.
- done  output  1  one-cycle pulse after last enable.

Behaviour:
- Reset: state=IDLE; en=0, busy=0, done=0; ctrl_vars all 0; delay_cnt=0; ii_cnt=0.
- State IDLE:
  - start=1 moves to DELAY when START_DELAY>0, otherwise to RUN.
  - In both cases busy goes high the next cycle.
- State DELAY:
  - delay_cnt increments each non-stalled cycle.
  - At delay_cnt==START_DELAY-1 (non-stalled), transition to RUN with ii_cnt=0.
- State RUN:
  - en is combinational: en = (ii_cnt==0) && !stall.
  - On an en cycle, ctrl_vars hold the current index. On the next edge the indices advance odometer-style:
    - [2] increments.
    - On [2]==EXT2-1, [2] wraps to 0 and [1] increments.
    - On [1]==EXT1-1, [1] wraps to 0 and [0] increments.
  - ii_cnt counts 0..II-1 on non-stalled cycles. II=1 gives en every non-stalled cycle.
- Last point: the en cycle with ctrl_vars == {EXT0-1, EXT1-1, EXT2-1}.
  - Next edge: state goes to IDLE, ctrl_vars clear to 0, done=1 for exactly one cycle, busy=0.
- Total enables per sweep: EXT0*EXT1*EXT2 exactly.
- Latency with no stall:
  - First en occurs START_DELAY+1 cycles after the start edge.
  - done occurs 1 cycle after the last en.
- stall=1 freezes delay_cnt, ii_cnt, indices and state, and forces en=0. Outputs other than en hold their values.
- start while busy is ignored, with no queuing. start in the cycle done is high is accepted, allowing back-to-back sweeps.
- flush=1, any state: next edge gives IDLE, all counters and ctrl_vars 0, en=0, done=0.
  - flush has priority over start, stall and completion.
- Arithmetic: all counters are unsigned CTRL_W bits. A loop with extent 2^CTRL_W wraps naturally at all-ones; no other overflow is possible within legal parameters.
- rst_n asserted mid-sweep: all state is cleared immediately (async); no done pulse.

Optional Feature:
- Macro: OP_CTRL_HALF_VARS_EN.
- Defined:
  - Adds output port `half_vars`, CTRL_W x [2:0].
  - half_vars[i] = ctrl_vars[i] >> 1, i.e. floor(v/2), combinational from the same registers.
  - Lets a nearest-neighbor read port address its source buffer with plain affine indexing.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic sweep. EXT0=1, EXT1=2, EXT2=3, START_DELAY=0, II=1; start pulse:
  - en high for 6 consecutive cycles beginning 1 cycle after start.
  - ctrl_vars[1:2] sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - done pulses once on the next cycle; busy falls with it.
- Delay and II. START_DELAY=4, II=3, EXT=(1,1,4):
  - First en at cycle 5 after start; subsequent ens at cycles 8, 11, 14.
  - done at 15.
- Stall. Base config with stall held 2 cycles during the 3rd enable:
  - en=0 for those 2 cycles and ctrl_vars frozen at (0,0,2).
  - Sequence resumes unchanged; still 6 enables total.
- Flush and start interaction:
  - Flush after the 4th enable: next cycle state IDLE, ctrl_vars=0, no done.
  - Fresh start then yields the full 6-enable sweep.
  - start asserted while busy: ignored, enable count unaffected.
- Back-to-back and reset:
  - start asserted in the done cycle: second sweep begins with no gap, 12 enables total.
  - rst_n low mid-sweep: en, busy, done and ctrl_vars go to 0 asynchronously.
- OP_CTRL_HALF_VARS_EN defined, EXT=(1,4,4):
  - half_vars[2] sequence per row is 0,0,1,1.
  - half_vars[1] equals 0 for rows 0–1 and 1 for rows 2–3.
